bicubic_result_writer: RTL and testbench

Write-back stage of the Bicubic scaler. It takes the stream of interpolated target pixels from the interpolation core and writes them into the result SRAM in raster order at address `row*128 + col`, covering a TW x TH window. It raises DONE once the last write has completed. DONE is the completion signal the top level exposes to the testfixture, which then reads the result SRAM directly.

---
 rtl/bicubic_result_writer.sv | 123 ++++++++++++
 tb/tb_bicubic_result_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_result_writer.sv
// rtl/bicubic_result_writer.sv - raster write-back of interpolated pixels into the result SRAM.
// Optional PIX_LAST protocol checking is enabled by defining LAST_CHECK_EN.
module bicubic_result_writer #(
  parameter int ROW_STRIDE = 128,
  parameter int AW         = 14
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [5:0]    TW,
  input  logic [5:0]    TH,
  input  logic          PIX_VALID,
  input  logic [7:0]    PIX_DATA,
  input  logic          PIX_LAST,
  output logic          PIX_READY,
  output logic          CEN,
  output logic          WEN,
  output logic [AW-1:0] A,
  output logic [7:0]    D,
  output logic          DONE,
  output logic          ERR
);

  localparam int SHIFT = $clog2(ROW_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [5:0] col, row;
  logic [5:0] tw_q, th_q;
  logic       hs;
  logic       col_end;
  logic       last_hs;
  logic       start_take;

  always_comb begin
    state_next = state;
    PIX_READY  = (state == S_RUN);
    hs         = PIX_VALID & (state == S_RUN);
    col_end    = (col == tw_q - 6'd1);
    last_hs    = hs & col_end & (row == th_q - 6'd1);
    start_take = START & ((state == S_IDLE) | (state == S_FIN));
    case (state)
      S_IDLE, S_FIN: begin
        if (START) begin
          state_next = ((TW == 6'd0) || (TH == 6'd0)) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (last_hs) begin
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: state_next = S_FIN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      col   <= 6'd0;
      row   <= 6'd0;
      tw_q  <= 6'd0;
      th_q  <= 6'd0;
      CEN   <= 1'b1;
      WEN   <= 1'b1;
      A     <= '0;
      D     <= 8'd0;
      DONE  <= 1'b0;
    end else begin
      state <= state_next;
      DONE  <= (state_next == S_FIN);
      CEN   <= ~hs;
      WEN   <= ~hs;
      if (hs) begin
        // ROW_STRIDE >= 64 keeps the column field clear of the row bits
        A <= (AW'(row) << SHIFT) | AW'(col);
        D <= PIX_DATA;
      end
      if (start_take) begin
        tw_q <= TW;
        th_q <= TH;
        col  <= 6'd0;
        row  <= 6'd0;
      end else if (hs) begin
        if (col_end) begin
          col <= 6'd0;
          row <= row + 6'd1;
        end else begin
          col <= col + 6'd1;
        end
      end
    end
  end

`ifdef LAST_CHECK_EN
  logic err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (start_take) begin
      err_q <= 1'b0;
    end else if (hs && (PIX_LAST != last_hs)) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  logic unused_last;

  assign unused_last = PIX_LAST;
  assign ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_bicubic_result_writer.sv
// tb/tb_bicubic_result_writer.sv - randomized bench for bicubic_result_writer with a raster-order write model.
module tb_bicubic_result_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [5:0]  TW = 6'd0;
  logic [5:0]  TH = 6'd0;
  logic        PIX_VALID = 1'b0;
  logic [7:0]  PIX_DATA = 8'd0;
  logic        PIX_LAST = 1'b0;
  logic        PIX_READY;
  logic        CEN;
  logic        WEN;
  logic [13:0] A;
  logic [7:0]  D;
  logic        DONE;
  logic        ERR;

  int n_checks = 0;
  int n_fail   = 0;

  int r_done, r_last_hs, r_cen_bad, r_rdy_bad, r_err_first, r_done_at1;
  int exp_a[$], exp_d[$], obs_a[$], obs_d[$];

  bicubic_result_writer #(.ROW_STRIDE(128), .AW(14)) dut (
    .CLK(CLK), .RST(RST), .START(START), .TW(TW), .TH(TH),
    .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_LAST(PIX_LAST),
    .PIX_READY(PIX_READY), .CEN(CEN), .WEN(WEN), .A(A), .D(D),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // vmode: 0 valid held high with data = pixel index, 1 valid toggling, 2 random valid/data.
  // A nonzero max_hs stops the frame right after that many handshakes.
  task automatic run_frame(input int tw, input int th, input int vmode, input int max_hs,
                           input bit start_mid, input int last_idx);
    int  total;
    int  acc;
    bit  prev_hs, hs, exp_rdy;
    total = tw * th;
    exp_a.delete(); exp_d.delete(); obs_a.delete(); obs_d.delete();
    r_done = -1; r_last_hs = -1; r_cen_bad = 0; r_rdy_bad = 0; r_err_first = -1; r_done_at1 = -1;
    START = 1'b1; TW = 6'(tw); TH = 6'(th); PIX_VALID = 1'b0; PIX_LAST = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0; TW = 6'($urandom); TH = 6'($urandom);
    acc = 0; prev_hs = 1'b0;
    for (int cyc = 1; cyc <= 9000; cyc++) begin
      case (vmode)
        0:       PIX_VALID = 1'b1;
        1:       PIX_VALID = cyc[0];
        default: PIX_VALID = 1'($urandom_range(0, 1));
      endcase
      PIX_DATA = (vmode == 0) ? 8'(acc) : 8'($urandom);
      PIX_LAST = (acc == last_idx);
      START    = start_mid && (cyc == 3);
      @(negedge CLK);
      exp_rdy = (acc < total);
      if (PIX_READY !== exp_rdy) r_rdy_bad++;
      if (CEN !== !prev_hs || WEN !== !prev_hs) r_cen_bad++;
      if (prev_hs) begin
        obs_a.push_back(int'(A));
        obs_d.push_back(int'(D));
      end
      if (ERR === 1'b1 && r_err_first < 0) r_err_first = cyc;
      if (cyc == 1) r_done_at1 = int'(DONE);
      if (DONE === 1'b1) begin
        r_done = cyc;
        break;
      end
      hs = exp_rdy && PIX_VALID;
      if (hs) begin
        exp_a.push_back((acc / tw) * 128 + (acc % tw));
        exp_d.push_back(int'(PIX_DATA));
        acc++;
        r_last_hs = cyc;
      end
      prev_hs = hs;
      @(posedge CLK); #1;
      if (max_hs > 0 && acc == max_hs) break;
    end
    START = 1'b0; PIX_VALID = 1'b0; PIX_LAST = 1'b0;
  endtask

  function automatic int write_diffs();
    int n;
    n = (exp_a.size() == obs_a.size()) ? 0 : 1;
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++)
      if (exp_a[i] != obs_a[i] || exp_d[i] != obs_d[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks += 7;
    if (PIX_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", PIX_READY); end
    if (CEN !== 1'b1) begin n_fail++; $display("FAIL reset_cen got %b want 1", CEN); end
    if (WEN !== 1'b1) begin n_fail++; $display("FAIL reset_wen got %b want 1", WEN); end
    if (A !== 14'd0) begin n_fail++; $display("FAIL reset_a got %0d want 0", A); end
    if (D !== 8'd0) begin n_fail++; $display("FAIL reset_d got %0d want 0", D); end
    if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", DONE); end
    if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", ERR); end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_basic_frame();
    run_frame(4, 3, 0, 0, 1'b0, 11);
    n_checks += 7;
    if (write_diffs() !== 0) begin n_fail++; $display("FAIL basic_writes got %0d diffs want 0", write_diffs()); end
    if (obs_a.size() !== 12) begin n_fail++; $display("FAIL basic_count got %0d want 12", obs_a.size()); end
    if (obs_a.size() == 12 && (obs_a[4] !== 128 || obs_a[11] !== 259 || obs_d[11] !== 11)) begin
      n_fail++; $display("FAIL basic_last got a=%0d d=%0d want a=259 d=11", obs_a[11], obs_d[11]);
    end
    if (r_done !== 14) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 14", r_done); end
    if (r_err_first !== -1) begin n_fail++; $display("FAIL basic_err got cycle %0d want none", r_err_first); end
    if (r_cen_bad !== 0) begin n_fail++; $display("FAIL basic_cen got %0d bad cycles want 0", r_cen_bad); end
    if (r_rdy_bad !== 0) begin n_fail++; $display("FAIL basic_ready got %0d bad cycles want 0", r_rdy_bad); end
  endtask

  task automatic test_backpressure();
    run_frame(5, 2, 1, 0, 1'b0, 9);
    n_checks += 6;
    if (write_diffs() !== 0) begin n_fail++; $display("FAIL bp_writes got %0d diffs want 0", write_diffs()); end
    if (obs_a.size() !== 10) begin n_fail++; $display("FAIL bp_count got %0d want 10", obs_a.size()); end
    if (obs_a.size() == 10 && obs_a[9] !== 132) begin n_fail++; $display("FAIL bp_last_addr got %0d want 132", obs_a[9]); end
    if (r_last_hs !== 19 || r_done !== 21) begin
      n_fail++; $display("FAIL bp_done got hs=%0d done=%0d want hs=19 done=21", r_last_hs, r_done);
    end
    if (r_cen_bad !== 0) begin n_fail++; $display("FAIL bp_cen got %0d bad cycles want 0", r_cen_bad); end
    if (r_rdy_bad !== 0) begin n_fail++; $display("FAIL bp_ready got %0d bad cycles want 0", r_rdy_bad); end
  endtask

  task automatic test_empty_window();
    run_frame(0, 7, 0, 0, 1'b0, -1);
    n_checks += 4;
    if (r_done !== 1) begin n_fail++; $display("FAIL empty_done got %0d want 1", r_done); end
    if (obs_a.size() !== 0) begin n_fail++; $display("FAIL empty_writes got %0d want 0", obs_a.size()); end
    if (r_cen_bad !== 0) begin n_fail++; $display("FAIL empty_cen got %0d bad cycles want 0", r_cen_bad); end
    if (r_rdy_bad !== 0) begin n_fail++; $display("FAIL empty_ready got %0d bad cycles want 0", r_rdy_bad); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    bad = 0;
    run_frame(8, 8, 0, 20, 1'b0, 63);
    RST = 1'b1; PIX_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (i == 3) RST = 1'b0;
      @(negedge CLK);
      if (CEN !== 1'b1 || DONE !== 1'b0 || PIX_READY !== 1'b0) bad++;
    end
    PIX_VALID = 1'b0;
    @(posedge CLK); #1;
    n_checks += 1;
    if (bad !== 0) begin n_fail++; $display("FAIL midreset_quiet got %0d bad cycles want 0", bad); end
    run_frame(2, 2, 2, 0, 1'b0, 3);
    n_checks += 3;
    if (write_diffs() !== 0) begin n_fail++; $display("FAIL midreset_restart got %0d diffs want 0", write_diffs()); end
    if (obs_a.size() !== 4 || (obs_a.size() == 4 && (obs_a[0] !== 0 || obs_a[3] !== 129))) begin
      n_fail++; $display("FAIL midreset_addrs got %0d writes want 0,1,128,129", obs_a.size());
    end
    if (r_done - r_last_hs !== 2) begin n_fail++; $display("FAIL midreset_done got %0d want %0d", r_done, r_last_hs + 2); end
  endtask

  task automatic test_restart_and_ignored_start();
    n_checks += 1;
    if (DONE !== 1'b1) begin n_fail++; $display("FAIL restart_pre_done got %b want 1", DONE); end
    run_frame(63, 63, 0, 0, 1'b1, 3968);
    n_checks += 5;
    if (r_done_at1 !== 0) begin n_fail++; $display("FAIL restart_done_drop got %0d want 0", r_done_at1); end
    if (obs_a.size() !== 3969) begin n_fail++; $display("FAIL restart_count got %0d want 3969", obs_a.size()); end
    if (obs_a.size() > 0 && obs_a[obs_a.size()-1] !== 7998) begin
      n_fail++; $display("FAIL restart_last_addr got %0d want 7998", obs_a[obs_a.size()-1]);
    end
    if (r_done !== 3971) begin n_fail++; $display("FAIL restart_done got %0d want 3971", r_done); end
    if (write_diffs() !== 0) begin n_fail++; $display("FAIL restart_writes got %0d diffs want 0", write_diffs()); end
  endtask

  task automatic test_random_frames();
    int tw, th;
    for (int it = 0; it < 5; it++) begin
      tw = $urandom_range(1, 9);
      th = $urandom_range(1, 9);
      run_frame(tw, th, 2, 0, 1'b0, tw * th - 1);
      n_checks += 3;
      if (write_diffs() !== 0) begin n_fail++; $display("FAIL rand_writes %0dx%0d got %0d diffs want 0", tw, th, write_diffs()); end
      if (r_done - r_last_hs !== 2) begin n_fail++; $display("FAIL rand_done %0dx%0d got %0d want %0d", tw, th, r_done, r_last_hs + 2); end
      if (r_cen_bad !== 0 || r_rdy_bad !== 0) begin
        n_fail++; $display("FAIL rand_ports %0dx%0d got cen=%0d ready=%0d bad cycles want 0", tw, th, r_cen_bad, r_rdy_bad);
      end
    end
  endtask

  task automatic test_last_check();
    int want;
`ifdef LAST_CHECK_EN
    want = 6;
`else
    want = -1;
`endif
    run_frame(3, 3, 0, 0, 1'b0, 4);
    n_checks += 3;
    if (r_err_first !== want) begin n_fail++; $display("FAIL last_early_err got cycle %0d want %0d", r_err_first, want); end
    if (obs_a.size() !== 9) begin n_fail++; $display("FAIL last_early_writes got %0d want 9", obs_a.size()); end
    if (r_done !== 11) begin n_fail++; $display("FAIL last_early_done got %0d want 11", r_done); end
    run_frame(3, 3, 0, 0, 1'b0, 8);
    n_checks += 2;
    if (r_err_first !== -1) begin n_fail++; $display("FAIL last_ok_err got cycle %0d want none", r_err_first); end
    if (write_diffs() !== 0) begin n_fail++; $display("FAIL last_ok_writes got %0d diffs want 0", write_diffs()); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_empty_window();
    test_reset_mid_frame();
    test_restart_and_ignored_start();
    test_random_frames();
    test_last_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
